// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU: opcodes, instruction layout, fixed widths.
package tiny_cpu_pkg;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int IW   = 24;
  localparam int NREG = 8;
  localparam int RW   = $clog2(NREG);

  localparam int OP_LSB  = 20;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 8;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6, OP_LDI = 4'h7,
    OP_LD   = 4'h8, OP_ST  = 4'h9, OP_JMP = 4'hA, OP_BZ  = 4'hB,
    OP_BNZ  = 4'hC, OP_MOV = 4'hD, OP_NOT = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  // Bit-exact overlay of the 24-bit instruction word; pad bits are don't-care.
  typedef struct packed {
    opcode_e         op;
    logic            pad0;
    logic [RW-1:0]   rd;
    logic            pad1;
    logic [RW-1:0]   rs1;
    logic            pad2;
    logic [RW-1:0]   rs2;
    logic [DW-1:0]   imm;
  } instr_t;

endpackage

// File: rtl/tiny_cpu_regfile.sv
// 8x8 register file: two combinational read ports, one synchronous write port, no reset.
module tiny_cpu_regfile
  import tiny_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [RW-1:0] ra1_i,
  input  logic [RW-1:0] ra2_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o
);

  // Left unreset so contents survive reset and can be preloaded by hierarchy.
  logic [DW-1:0] rf [0:NREG-1];

  always_ff @(posedge clk) begin
    if (we_i) rf[wa_i] <= wd_i;
  end

  assign rd1_o = rf[ra1_i];
  assign rd2_o = rf[ra2_i];

endmodule

// File: rtl/tiny_cpu.sv
// Single-cycle 8-bit load/store core: combinational decode of rom_data, one instruction per clock.
module tiny_cpu
  import tiny_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdat,
  input  logic [DW-1:0] ram_rdat,
  output logic          ram_rd_,
  output logic          ram_wr_
);

  instr_t        ins;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] rs1_v, rs2_v, ea, wd;
  logic          we, rd_n, wr_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdat;
  logic          unused_pad;

  assign ins        = instr_t'(rom_data);
  assign unused_pad = ^{ins.pad0, ins.pad1, ins.pad2};
  assign ea         = rs1_v + ins.imm;

  tiny_cpu_regfile regfile (
    .clk   (clk),
    .we_i  (we),
    .wa_i  (ins.rd),
    .wd_i  (wd),
    .ra1_i (ins.rs1),
    .ra2_i (ins.rs2),
    .rd1_o (rs1_v),
    .rd2_o (rs2_v)
  );

  always_comb begin
    pc_d = pc_q + 8'd1;
    we   = 1'b0;
    wd   = '0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    addr = '0;
    wdat = '0;
    case (ins.op)
      OP_NOP:  ;
      OP_ADD:  begin we = 1'b1; wd = rs1_v + rs2_v;  end
      OP_SUB:  begin we = 1'b1; wd = rs1_v - rs2_v;  end
      OP_AND:  begin we = 1'b1; wd = rs1_v & rs2_v;  end
      OP_OR:   begin we = 1'b1; wd = rs1_v | rs2_v;  end
      OP_XOR:  begin we = 1'b1; wd = rs1_v ^ rs2_v;  end
      OP_ADDI: begin we = 1'b1; wd = ea;             end
      OP_LDI:  begin we = 1'b1; wd = ins.imm;        end
      OP_LD:   begin we = 1'b1; wd = ram_rdat; rd_n = 1'b0; addr = ea; end
      OP_ST:   begin wr_n = 1'b0; addr = ea; wdat = rs2_v; end
      OP_JMP:  pc_d = ins.imm;
      OP_BZ:   if (rs1_v == '0) pc_d = ins.imm;
      OP_BNZ:  if (rs1_v != '0) pc_d = ins.imm;
      OP_MOV:  begin we = 1'b1; wd = rs1_v;          end
      OP_NOT:  begin we = 1'b1; wd = ~rs1_v;         end
      OP_HLT:  pc_d = pc_q;
    endcase
    // Reset is asynchronous, so memory strobes and register writes are masked combinationally too.
    if (!rst_) begin
      we   = 1'b0;
      rd_n = 1'b1;
      wr_n = 1'b1;
      addr = '0;
      wdat = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign rom_addr = pc_q;
  assign ram_addr = addr;
  assign ram_wdat = wdat;
  assign ram_rd_  = rd_n;
  assign ram_wr_  = wr_n;

endmodule

// File: tb/tb_tiny_cpu.sv
// Bench for tiny_cpu: directed program from the block description, then random programs vs an ISA-level model.
module tb_tiny_cpu;

  logic        clk  = 1'b1;
  logic        rst_ = 1'b0;
  logic [7:0]  rom_addr, ram_addr, ram_wdat, ram_rdat;
  logic [23:0] rom_data;
  logic        ram_rd_, ram_wr_;

  logic [23:0] rom     [0:255];
  logic [7:0]  ram     [0:255];
  logic [7:0]  ram_img [0:255];
  logic        ram_load = 1'b0;

  logic [7:0]  m_rf  [0:7];
  logic [7:0]  m_ram [0:255];
  logic [7:0]  m_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tiny_cpu dut (
    .clk      (clk),
    .rst_     (rst_),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ram_addr (ram_addr),
    .ram_wdat (ram_wdat),
    .ram_rdat (ram_rdat),
    .ram_rd_  (ram_rd_),
    .ram_wr_  (ram_wr_)
  );

  assign rom_data = rom[rom_addr];
  assign ram_rdat = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_img[i];
    end else if (!ram_wr_) begin
      ram[ram_addr] <= ram_wdat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [23:0] w;
    w = '0;
    w[23:20] = 4'(op);
    w[18:16] = 3'(rd);
    w[14:12] = 3'(rs1);
    w[10:8]  = 3'(rs2);
    w[7:0]   = 8'(imm);
    return w;
  endfunction

  // ISA-level reference: one instruction per call, integer arithmetic reduced mod 256.
  task automatic m_step();
    logic [23:0] w;
    int op, rd, a, b, imm, nxt;
    w   = rom[m_pc];
    op  = int'(w[23:20]);
    rd  = int'(w[18:16]);
    a   = int'(m_rf[w[14:12]]);
    b   = int'(m_rf[w[10:8]]);
    imm = int'(w[7:0]);
    nxt = (int'(m_pc) + 1) % 256;
    case (op)
      1:  m_rf[rd] = 8'((a + b) % 256);
      2:  m_rf[rd] = 8'((a - b + 256) % 256);
      3:  m_rf[rd] = 8'(a & b);
      4:  m_rf[rd] = 8'(a | b);
      5:  m_rf[rd] = 8'(a ^ b);
      6:  m_rf[rd] = 8'((a + imm) % 256);
      7:  m_rf[rd] = 8'(imm);
      8:  m_rf[rd] = m_ram[(a + imm) % 256];
      9:  m_ram[(a + imm) % 256] = 8'(b);
      10: nxt = imm;
      11: if (a == 0) nxt = imm;
      12: if (a != 0) nxt = imm;
      13: m_rf[rd] = 8'(a);
      14: m_rf[rd] = 8'(255 - a);
      15: nxt = int'(m_pc);
      default: ;
    endcase
    m_pc = 8'(nxt);
  endtask

  task automatic check_comb();
    logic [23:0] w;
    int op, a, b, imm;
    w   = rom[m_pc];
    op  = int'(w[23:20]);
    a   = int'(m_rf[w[14:12]]);
    b   = int'(m_rf[w[10:8]]);
    imm = int'(w[7:0]);
    chk("rom_addr", rom_addr, m_pc);
    chk("ram_rd_", ram_rd_, (op == 8) ? 0 : 1);
    chk("ram_wr_", ram_wr_, (op == 9) ? 0 : 1);
    if (op == 8 || op == 9) chk("ram_addr", ram_addr, (a + imm) % 256);
    if (op == 9) chk("ram_wdat", ram_wdat, b);
  endtask

  task automatic check_state();
    chk("pc", rom_addr, m_pc);
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), dut.regfile.rf[i], m_rf[i]);
  endtask

  task automatic chk_reset_outs();
    chk("rst_pc", rom_addr, 0);
    chk("rst_rd_", ram_rd_, 1);
    chk("rst_wr_", ram_wr_, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdat", ram_wdat, 0);
  endtask

  // Entered and left just after a falling edge.
  task automatic cycle();
    check_comb();
    @(posedge clk);
    m_step();
    #1;
    check_state();
    @(negedge clk);
  endtask

  task automatic reset_mid();
    rst_ = 1'b0;
    #1;
    chk_reset_outs();
    for (int i = 0; i < 8; i++) chk($sformatf("rst_keep_rf%0d", i), dut.regfile.rf[i], m_rf[i]);
    m_pc = 8'h00;
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_ = 1'b1;
    #1;
  endtask

  task automatic preload_regs();
    for (int i = 0; i < 8; i++) dut.regfile.rf[i] <= m_rf[i];
  endtask

  initial begin
    int bad;
    // ---- directed program ----
    for (int i = 0; i < 256; i++) begin
      rom[i]     = enc(0, 0, 0, 0, 0);
      ram_img[i] = 8'h00;
      m_ram[i]   = 8'h00;
    end
    rom[8'h00] = enc(1, 0, 1, 2, 0);
    rom[8'h01] = enc(2, 3, 1, 2, 0);
    rom[8'h02] = enc(1, 4, 7, 1, 0);
    rom[8'h03] = enc(6, 5, 7, 0, 8'h02);
    rom[8'h04] = enc(7, 6, 0, 0, 8'h5A);
    rom[8'h05] = enc(9, 0, 0, 6, 8'h10);
    rom[8'h06] = enc(8, 1, 0, 0, 8'h10);
    rom[8'h07] = enc(11, 0, 3, 0, 8'h20);
    rom[8'h08] = enc(7, 2, 0, 0, 8'h00);
    rom[8'h09] = enc(11, 0, 2, 0, 8'h20);
    rom[8'h20] = enc(10, 0, 0, 0, 8'h40);
    rom[8'h40] = enc(5, 7, 6, 3, 0);
    rom[8'h41] = enc(14, 4, 7, 0, 0);
    rom[8'h42] = enc(4, 5, 4, 5, 0);
    rom[8'h43] = enc(3, 0, 5, 3, 0);
    rom[8'h44] = enc(13, 2, 5, 0, 0);
    rom[8'h45] = enc(12, 0, 2, 0, 8'h47);
    rom[8'h46] = enc(15, 0, 0, 0, 0);
    rom[8'h47] = enc(0, 0, 0, 0, 0);
    rom[8'h48] = enc(15, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) m_rf[i] = 8'(i);
    m_rf[7] = 8'hFF;
    m_pc = 8'h00;
    preload_regs();
    ram_load = 1'b1;
    #5;
    chk_reset_outs();
    @(posedge clk);
    #1 ram_load = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    #1;

    cycle(); chk("add_r0", dut.regfile.rf[0], 8'h03); chk("pc_1", rom_addr, 8'h01);
    cycle(); chk("sub_r3", dut.regfile.rf[3], 8'hFF); chk("pc_2", rom_addr, 8'h02);
    cycle(); chk("add_wrap_r4", dut.regfile.rf[4], 8'h00);
    cycle(); chk("addi_wrap_r5", dut.regfile.rf[5], 8'h01);
    cycle(); chk("ldi_r6", dut.regfile.rf[6], 8'h5A);
    chk("st_wr_low", ram_wr_, 0); chk("st_addr", ram_addr, 8'h13); chk("st_wdat", ram_wdat, 8'h5A);
    cycle(); chk("st_ram13", ram[8'h13], 8'h5A);
    chk("st_wr_one_cycle", ram_wr_, 1); chk("ld_rd_low", ram_rd_, 0);
    cycle(); chk("ld_r1", dut.regfile.rf[1], 8'h5A);
    cycle(); chk("bz_not_taken", rom_addr, 8'h08);
    cycle(); chk("ldi_r2_zero", dut.regfile.rf[2], 8'h00);
    cycle(); chk("bz_taken", rom_addr, 8'h20);
    cycle(); chk("jmp", rom_addr, 8'h40);
    cycle(); chk("xor_r7", dut.regfile.rf[7], 8'hA5);
    cycle(); chk("not_r4", dut.regfile.rf[4], 8'h5A);
    cycle(); chk("or_r5", dut.regfile.rf[5], 8'h5B);
    cycle(); chk("and_r0", dut.regfile.rf[0], 8'h5B);
    cycle(); chk("mov_r2", dut.regfile.rf[2], 8'h5B);
    cycle(); chk("bnz_taken", rom_addr, 8'h47);
    cycle(); chk("nop_pc", rom_addr, 8'h48);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("hlt_pc", rom_addr, 8'h48);
      chk("hlt_wr", ram_wr_, 1);
    end
    chk("hlt_r6", dut.regfile.rf[6], 8'h5A);

    reset_mid();
    cycle(); chk("restart_add_r0", dut.regfile.rf[0], 8'hB5); chk("restart_pc", rom_addr, 8'h01);
    for (int i = 0; i < 3; i++) cycle();
    reset_mid();
    for (int i = 0; i < 30; i++) cycle();
    chk("rerun_halt_pc", rom_addr, 8'h48);

    // ---- random programs ----
    for (int p = 0; p < 4; p++) begin
      rst_ = 1'b0;
      for (int i = 0; i < 256; i++) begin
        int r;
        logic [23:0] w;
        r = int'($urandom_range(0, 63));
        w = 24'($urandom);
        w[23:20] = (r == 0) ? 4'hF : 4'(r % 15);
        rom[i]     = w;
        ram_img[i] = 8'($urandom);
        m_ram[i]   = ram_img[i];
      end
      for (int i = 0; i < 8; i++) m_rf[i] = 8'($urandom);
      m_pc = 8'h00;
      preload_regs();
      ram_load = 1'b1;
      #1;
      chk_reset_outs();
      @(posedge clk);
      #1 ram_load = 1'b0;
      check_state();
      @(negedge clk);
      rst_ = 1'b1;
      #1;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 49) == 0) reset_mid();
        else cycle();
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== m_ram[i]) bad++;
      chk("ram_image", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
